// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: data-hazard stall, mult/div busy tracking,
// memory-wait freeze with timeout, and a stall-cycle performance counter.
module pipe_stall_ctrl #(
  parameter int MULT_CYC    = 5,
  parameter int DIV_CYC     = 10,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic        D_use_rs,
  input  logic        D_use_rt,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_md,
  input  logic [4:0]  E_dst,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_dst,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        F_en,
  output logic        D_en,
  output logic        E_en,
  output logic        M_en,
  output logic        E_flush,
  output logic        md_busy,
  output logic        mem_err,
  output logic [31:0] stall_cycles
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {MS_IDLE = 1'b0, MS_WAIT = 1'b1} mem_state_t;

  mem_state_t     state_r, state_nxt_s;
  logic [WCW-1:0] wait_cnt_r, wait_cnt_nxt_s;
  logic [3:0]     md_cnt_r;
  logic           mem_err_r, mem_err_nxt_s;
  logic [31:0]    stall_cycles_r;
  logic           freeze_s, stall_s, stall_rs_s, stall_rt_s, stall_md_s;

  // Operand hazard: a producer in E or M whose result arrives later than the consumer needs it.
  always_comb begin
    stall_rs_s = D_use_rs & (D_rs != 5'd0) &
                 (((D_rs == E_dst) & (E_Tnew > D_Tuse_rs)) |
                  ((D_rs == M_dst) & (M_Tnew > D_Tuse_rs)));
    stall_rt_s = D_use_rt & (D_rt != 5'd0) &
                 (((D_rt == E_dst) & (E_Tnew > D_Tuse_rt)) |
                  ((D_rt == M_dst) & (M_Tnew > D_Tuse_rt)));
    stall_md_s = D_md & (md_busy | E_md_start);
    stall_s    = stall_rs_s | stall_rt_s | stall_md_s;
  end

  // Memory-wait FSM next state; the final WAIT cycle still freezes before the access is abandoned.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    mem_err_nxt_s  = 1'b0;
    freeze_s       = 1'b0;
    case (state_r)
      MS_IDLE: begin
        if (mem_req & ~mem_ack) begin
          freeze_s       = 1'b1;
          state_nxt_s    = MS_WAIT;
          wait_cnt_nxt_s = '0;
        end else begin
          state_nxt_s = MS_IDLE;
        end
      end
      MS_WAIT: begin
        if (mem_ack) begin
          state_nxt_s = MS_IDLE;
        end else begin
          freeze_s = 1'b1;
          if (wait_cnt_r == WAIT_LAST) begin
            mem_err_nxt_s = 1'b1;
            state_nxt_s   = MS_IDLE;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
          end
        end
      end
      default: state_nxt_s = MS_IDLE;
    endcase
  end

  // Register enables and bubble insertion; a freeze overrides any stall.
  always_comb begin
    F_en    = 1'b1;
    D_en    = 1'b1;
    E_en    = 1'b1;
    M_en    = 1'b1;
    E_flush = 1'b0;
    if (freeze_s) begin
      F_en = 1'b0;
      D_en = 1'b0;
      E_en = 1'b0;
      M_en = 1'b0;
    end else if (stall_s) begin
      F_en    = 1'b0;
      E_flush = 1'b1;
    end else begin
      F_en = 1'b1;
    end
  end

  // FSM state, wait counter and timeout pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= MS_IDLE;
      wait_cnt_r <= '0;
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      mem_err_r  <= mem_err_nxt_s;
    end
  end

  // Mult/div busy counter; a start during a freeze is ignored, but counting continues.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_r <= 4'd0;
    end else if (E_md_start & ~freeze_s) begin
      md_cnt_r <= E_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
    end else if (md_cnt_r != 4'd0) begin
      md_cnt_r <= md_cnt_r - 4'd1;
    end else begin
      md_cnt_r <= md_cnt_r;
    end
  end

  // Count every cycle the front end is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_r <= 32'd0;
    end else if (!F_en) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign md_busy      = (md_cnt_r != 4'd0);
  assign mem_err      = mem_err_r;
  assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_dst, M_dst;
  logic        D_use_rs, D_use_rt, D_md, E_md_start, E_md_div, mem_req, mem_ack;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        F_en, D_en, E_en, M_en, E_flush, md_busy, mem_err;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_sc;

  localparam logic [31:0] EN_RUN   = 32'h0000_001E;
  localparam logic [31:0] EN_STALL = 32'h0000_000F;
  localparam logic [31:0] EN_FRZ   = 32'h0000_0000;

  pipe_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_md(D_md),
    .E_dst(E_dst), .E_Tnew(E_Tnew), .M_dst(M_dst), .M_Tnew(M_Tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .F_en(F_en), .D_en(D_en), .E_en(E_en), .M_en(M_en), .E_flush(E_flush),
    .md_busy(md_busy), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] en_vec();
    return {27'd0, F_en, D_en, E_en, M_en, E_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr_in();
    D_rs = 5'd0; D_rt = 5'd0; D_use_rs = 1'b0; D_use_rt = 1'b0;
    D_Tuse_rs = 2'd0; D_Tuse_rt = 2'd0; D_md = 1'b0;
    E_dst = 5'd0; E_Tnew = 2'd0; M_dst = 5'd0; M_Tnew = 2'd0;
    E_md_start = 1'b0; E_md_div = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clr_in();
    exp_sc = 32'd0;
    #3;
    chk("reset_en", en_vec(), EN_RUN);
    chk("reset_busy", 32'(md_busy), 32'd0);
    chk("reset_sc", stall_cycles, 32'd0);
    chk("reset_err", 32'(mem_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Load-use hazard against E
    E_dst = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_use_rs = 1'b1; D_Tuse_rs = 2'd0;
    settle();
    chk("loaduse_en", en_vec(), EN_STALL);
    tick(); exp_sc = exp_sc + 32'd1;
    chk("loaduse_sc", stall_cycles, exp_sc);
    E_Tnew = 2'd0;
    settle();
    chk("tnew0_en", en_vec(), EN_RUN);
    tick();
    chk("tnew0_sc", stall_cycles, exp_sc);

    // Hazard against M, then the equal-timing boundary
    E_dst = 5'd0; M_dst = 5'd8; M_Tnew = 2'd2; D_Tuse_rs = 2'd1;
    settle();
    chk("m_hazard_en", en_vec(), EN_STALL);
    tick(); exp_sc = exp_sc + 32'd1;
    M_Tnew = 2'd1;
    settle();
    chk("m_equal_en", en_vec(), EN_RUN);
    tick();

    // $0 never stalls; an unused rt never stalls; a used rt does
    clr_in();
    D_rs = 5'd0; D_use_rs = 1'b1; E_dst = 5'd0; E_Tnew = 2'd2;
    settle();
    chk("zero_reg_en", en_vec(), EN_RUN);
    tick();
    clr_in();
    D_rt = 5'd9; D_use_rt = 1'b0; M_dst = 5'd9; M_Tnew = 2'd3; D_Tuse_rt = 2'd0;
    settle();
    chk("no_use_rt_en", en_vec(), EN_RUN);
    D_use_rt = 1'b1;
    settle();
    chk("use_rt_en", en_vec(), EN_STALL);
    tick(); exp_sc = exp_sc + 32'd1;
    chk("use_rt_sc", stall_cycles, exp_sc);
    clr_in();

    // Div: start with D_md already waiting, then 10 busy cycles
    E_md_start = 1'b1; E_md_div = 1'b1; D_md = 1'b1;
    settle();
    chk("div_start_busy", 32'(md_busy), 32'd0);
    chk("div_start_en", en_vec(), EN_STALL);
    tick(); exp_sc = exp_sc + 32'd1;
    E_md_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk($sformatf("div_busy_%0d", i), 32'(md_busy), 32'd1);
      chk($sformatf("div_stall_%0d", i), en_vec(), EN_STALL);
      tick(); exp_sc = exp_sc + 32'd1;
    end
    settle();
    chk("div_done_busy", 32'(md_busy), 32'd0);
    chk("div_done_en", en_vec(), EN_RUN);
    chk("div_sc", stall_cycles, exp_sc);
    clr_in();

    // Mult: 5 busy cycles, no consumer waiting
    E_md_start = 1'b1; E_md_div = 1'b0;
    tick();
    E_md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("mul_busy_%0d", i), 32'(md_busy), 32'd1);
      chk($sformatf("mul_en_%0d", i), en_vec(), EN_RUN);
      tick();
    end
    chk("mul_done_busy", 32'(md_busy), 32'd0);

    // Memory wait: ack low for 3 cycles, mult start during freeze is dropped
    mem_req = 1'b1; mem_ack = 1'b0; E_md_start = 1'b1;
    settle();
    chk("memw_idle_en", en_vec(), EN_FRZ);
    tick(); exp_sc = exp_sc + 32'd1;
    E_md_start = 1'b0;
    chk("memw_md_ignored", 32'(md_busy), 32'd0);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("memw_wait_%0d", i), en_vec(), EN_FRZ);
      tick(); exp_sc = exp_sc + 32'd1;
    end
    mem_ack = 1'b1;
    settle();
    chk("memw_ack_en", en_vec(), EN_RUN);
    tick();
    mem_req = 1'b0; mem_ack = 1'b0;
    settle();
    chk("memw_idle_after", en_vec(), EN_RUN);
    chk("memw_sc", stall_cycles, exp_sc);
    tick();
    mem_req = 1'b1; mem_ack = 1'b1;
    settle();
    chk("mem_same_cycle_en", en_vec(), EN_RUN);
    tick();
    mem_req = 1'b0; mem_ack = 1'b0;
    settle();
    chk("mem_same_cycle_idle", en_vec(), EN_RUN);
    tick();

    // Timeout with a concurrent data hazard: freeze wins, stall follows
    mem_req = 1'b1;
    E_dst = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_use_rs = 1'b1;
    for (int i = 0; i < 17; i++) begin
      settle();
      chk($sformatf("tmo_frz_%0d", i), en_vec(), EN_FRZ);
      chk($sformatf("tmo_err_%0d", i), 32'(mem_err), 32'd0);
      tick(); exp_sc = exp_sc + 32'd1;
    end
    mem_req = 1'b0;
    settle();
    chk("tmo_err_pulse", 32'(mem_err), 32'd1);
    chk("tmo_stall_en", en_vec(), EN_STALL);
    tick(); exp_sc = exp_sc + 32'd1;
    chk("tmo_err_clear", 32'(mem_err), 32'd0);
    chk("tmo_sc", stall_cycles, exp_sc);
    clr_in();
    settle();
    chk("tmo_run_en", en_vec(), EN_RUN);
    tick();

    // Reset during WAIT with md_cnt = 7
    E_md_start = 1'b1; E_md_div = 1'b1;
    tick();
    E_md_start = 1'b0; mem_req = 1'b1;
    tick(); tick(); tick();
    settle();
    chk("pre_reset_busy", 32'(md_busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_sc", stall_cycles, 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    mem_req = 1'b0;
    #1;
    chk("rst_idle_en", en_vec(), EN_RUN);
    @(negedge clk);
    reset = 1'b1;
    tick();
    settle();
    chk("post_rst_en", en_vec(), EN_RUN);
    chk("post_rst_busy", 32'(md_busy), 32'd0);
    E_dst = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_use_rs = 1'b1;
    settle();
    chk("post_rst_stall", en_vec(), EN_STALL);
    tick();
    chk("post_rst_sc", stall_cycles, 32'd1);
    clr_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
